sum_accumulator: RTL and testbench
==================================

# sum_accumulator

Sequential stage directly downstream of the 4-bit ripple-carry adder. It consumes the adder's 5-bit result ({cout, s}) under a valid/ready handshake and accumulates a frame of COUNT results, or fewer if the frame is ended early by in_last. It then presents the frame total with a sticky overflow flag on a registered valid/ready output port. It is the first clocked element after the combinational adder datapath.

## Interface
- ACC_W, 8, accumulator and result width in bits (≥ 5)
- COUNT, 4, adder results per frame (≥ 1)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream adder result valid
- in_ready  output  1  block accepts an input this cycle
- s  input  4  adder sum bits
- cout  input  1  adder carry-out
- in_last  input  1  accepted input is the last of the frame (early termination)
- out_valid  output  1  frame result valid
- out_ready  input  1  downstream accepts the result
- acc_out  output  ACC_W  frame total
- ovf  output  1  frame total exceeded ACC_W bits (sticky per frame)

## Operation
- Operand value v = {cout, s}, zero-extended to ACC_W; range 0..31.
- Accept = in_valid & in_ready. Release = out_valid & out_ready.
- State IDLE (reset state): in_ready=0, out_valid=0. Moves to ACCUM unconditionally on the next clk.
- State ACCUM: in_ready=1, out_valid=0. On accept:
  - acc ← acc + v, computed at ACC_W+1 bits.
  - If bit ACC_W of that sum is set, ovf ← 1.
  - cnt ← cnt + 1.
  - If cnt+1 == COUNT or in_last=1, go to DONE.
- State DONE: in_ready=0, out_valid=1, and acc_out/ovf held stable. On release: acc←0, ovf←0, cnt←0, go to ACCUM.
- in_last is sampled only on accept. If in_last=1 on the COUNT-th input, the frame still ends exactly once.
- With in_valid=0, ACCUM holds all state indefinitely. With out_ready=0, DONE holds indefinitely. Inputs presented while in DONE are not consumed.
- Counter width is enough to hold COUNT. cnt never exceeds COUNT−1 in ACCUM.
- Wrap mode (default): acc is kept modulo 2^ACC_W.

## Timing
- Reset (asynchronous, immediate) drives: state=IDLE, acc=0, cnt=0, ovf=0, in_ready=0, out_valid=0, acc_out=0.
- The first possible accept is on the 2nd rising edge after rst deasserts (IDLE→ACCUM on the 1st).
- All outputs are registered or decoded from state only. There are no combinational paths from inputs to outputs.
- Latency: the last accept at edge N gives out_valid=1 after edge N, with the final total on acc_out.
- Result then new frame: release at edge M gives in_ready=1 after edge M, so the next accept is possible at edge M+1. Minimum frame period is COUNT+1 cycles.
- rst asserted mid-frame or in DONE discards the partial or pending result with no output pulse.

## Configuration
- SUM_ACC_SAT_EN defined: when an add overflows, acc saturates to all-ones (2^ACC_W−1), and all later adds in the frame keep it saturated. ovf behaves identically.
- SUM_ACC_SAT_EN undefined: wrap mode as specified above.

## Test plan
- Reset/startup: hold rst 3 cycles with in_valid=1 → in_ready=0 and out_valid=0 throughout, and in_ready=1 exactly one cycle after release.
- Nominal frame (defaults): accept {cout,s} = 5'd31, 5'd1, 5'd16, 5'd0 back-to-back → out_valid after 4th accept, acc_out=8'd48, ovf=0, in_ready=0 while out_valid.
- Early termination: accept 5'd10, 5'd7 with in_last=1 on the second → acc_out=8'd17 after 2 inputs. After release, the next frame starts from 0.
- Overflow, ACC_W=8, COUNT=10, ten inputs of 5'd31 (total 310) → wrap build: acc_out=8'd54, ovf=1. SUM_ACC_SAT_EN build: acc_out=8'd255, ovf=1. Next frame shows ovf=0.
- Back-pressure: hold out_ready=0 for 5 cycles with in_valid=1 and changing s → acc_out stable and no inputs consumed. Release then occurs on the first out_ready=1 edge.
- Mid-frame reset: after 2 of 4 accepts, pulse rst asynchronously between edges → all outputs 0 immediately. A new full frame of 4×5'd2 then yields acc_out=8'd8.

Source files
------------

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//
// First clocked stage after the 4-bit ripple-carry adder. Accepts the 5-bit
// adder result {cout, s} under a valid/ready handshake. It accumulates a frame
// of COUNT results, or fewer if in_last ends the frame early. It then holds the
// frame total and a sticky overflow flag on a valid/ready output port until
// downstream takes them.
//
// Parameters
//   ACC_W  accumulator / result width in bits (>= 5)
//   COUNT  adder results per frame (>= 1)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream adder result valid
//   in_ready   block accepts an input this cycle
//   s, cout    adder sum bits and carry-out (operand = {cout, s})
//   in_last    accepted input is the last of the frame
//   out_valid  frame result valid
//   out_ready  downstream accepts the result
//   acc_out    frame total
//   ovf        frame total exceeded ACC_W bits (sticky per frame)
//
// Build option
//   SUM_ACC_SAT_EN  when defined, an overflowing add saturates the accumulator
//                   to all-ones instead of wrapping modulo 2^ACC_W.
// ---------------------------------------------------------------------------
module sum_accumulator #(
    parameter int ACC_W = 8,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       s,
    input  logic             cout,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             ovf
);

    localparam int CNT_W = $clog2(COUNT + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf_q;

    logic             accept;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_add;
    logic [CNT_W-1:0] cnt_inc;
    logic             frame_end;

    // Handshake flags are pure state decodes, so no input reaches an output
    // combinationally.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign acc_out   = acc;
    assign ovf       = ovf_q;

    assign accept = in_valid && in_ready;

    // One extra bit on the add so the carry out of ACC_W bits is visible.
    assign sum       = {1'b0, acc} + {{(ACC_W - 4){1'b0}}, cout, s};
    assign cnt_inc   = cnt + 1'b1;
    assign frame_end = (cnt_inc == CNT_W'(COUNT)) || in_last;

`ifdef SUM_ACC_SAT_EN
    // Once saturated, any further add overflows again (or adds zero), so the
    // accumulator stays pinned at all-ones for the rest of the frame.
    assign acc_add = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_add = sum[ACC_W-1:0];
`endif

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= ACCUM;
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_add;
                        cnt <= cnt_inc;
                        if (sum[ACC_W]) ovf_q <= 1'b1;
                        if (frame_end) state <= DONE;
                    end
                end
                DONE: begin
                    // acc/ovf are untouched here, so the result stays stable
                    // for as long as downstream stalls.
                    if (out_ready) begin
                        acc   <= '0;
                        cnt   <= '0;
                        ovf_q <= 1'b0;
                        state <= ACCUM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//
// Self-checking bench for sum_accumulator. The bench uses two instances:
//   u_dut  default parameters (ACC_W=8, COUNT=4). It runs the directed and
//          randomized traffic against a frame-level reference model.
//   u_big  COUNT=10. It exercises frame overflow (ten inputs of 31).
// The model keeps the frame as a running integer total. It derives the
// expected result from plain arithmetic: wrap is modulo 2^ACC_W, and
// saturation clamps at 2^ACC_W-1.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

    localparam int ACC_W = 8;
    localparam int COUNT = 4;
    localparam int LIMIT = 1 << ACC_W;

    logic clk = 1'b0;
    logic rst;

    // default-size instance
    logic             in_valid, in_ready, in_last, out_valid, out_ready, ovf, cout;
    logic [3:0]       s;
    logic [ACC_W-1:0] acc_out;

    // COUNT=10 instance
    logic             b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_ovf, b_cout;
    logic [3:0]       b_s;
    logic [ACC_W-1:0] b_acc_out;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state for u_dut
    bit m_started;
    bit m_pending;
    int m_total;
    int m_n;

    always #5 clk = ~clk;

    sum_accumulator #(.ACC_W(ACC_W), .COUNT(COUNT)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .cout(cout), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .ovf(ovf)
    );

    sum_accumulator #(.ACC_W(ACC_W), .COUNT(10)) u_big (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .s(b_s), .cout(b_cout), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .acc_out(b_acc_out), .ovf(b_ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_result(input int total);
`ifdef SUM_ACC_SAT_EN
        return (total >= LIMIT) ? LIMIT - 1 : total;
`else
        return total % LIMIT;
`endif
    endfunction

    task automatic model_reset();
        m_started = 1'b0;
        m_pending = 1'b0;
        m_total   = 0;
        m_n       = 0;
    endtask

    // Check u_dut against the model, advance one rising edge, then update the
    // model with the inputs that were present at that edge. The task returns
    // on the following falling edge, which is where the caller changes inputs.
    task automatic cycle();
        check("in_ready", {31'd0, in_ready}, {31'd0, m_started && !m_pending});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_pending});
        if (m_pending) begin
            check("acc_out", 32'(acc_out), 32'(exp_result(m_total)));
            check("ovf", {31'd0, ovf}, {31'd0, m_total >= LIMIT});
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (!m_started) begin
            m_started = 1'b1;
        end else if (m_pending) begin
            if (out_ready) begin
                m_pending = 1'b0;
                m_total   = 0;
                m_n       = 0;
            end
        end else if (in_valid) begin
            m_total += int'({cout, s});
            m_n++;
            if (m_n == COUNT || in_last) m_pending = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [4:0] v, input logic last);
        in_valid = 1'b1;
        {cout, s} = v;
        in_last = last;
        cycle();
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b0; {cout, s} = 5'd0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_out_ready = 1'b0; {b_cout, b_s} = 5'd0;
        @(negedge clk);

        // Reset held for 3 cycles with in_valid=1; the model expects no ready/valid.
        repeat (3) cycle();
        rst = 1'b0;
        cycle();                               // IDLE -> ACCUM edge

        // Nominal frame: 31 + 1 + 16 + 0 = 48.
        send(5'd31, 1'b0);                     // first check: in_ready=1 one cycle after release
        send(5'd1, 1'b0);
        send(5'd16, 1'b0);
        send(5'd0, 1'b0);
        check("nominal_acc", 32'(acc_out), 32'd48);
        check("nominal_ovf", {31'd0, ovf}, 32'd0);
        check("nominal_valid", {31'd0, out_valid}, 32'd1);

        // Back-pressure: changing inputs while DONE must not be consumed.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            {cout, s} = 5'($urandom_range(0, 31));
            in_last = 1'($urandom_range(0, 1));
            cycle();
            check("bp_acc_stable", 32'(acc_out), 32'd48);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cycle();                               // release on first out_ready edge
        out_ready = 1'b0;
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);

        // Early termination after two inputs: 10 + 7.
        send(5'd10, 1'b0);
        send(5'd7, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        check("early_acc", 32'(acc_out), 32'd17);
        cycle();
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("early_cleared", 32'(acc_out), 32'd0);

        // in_last on the COUNT-th input ends the frame only once.
        send(5'd3, 1'b0);
        send(5'd3, 1'b0);
        send(5'd3, 1'b0);
        send(5'd3, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        check("last_on_count_acc", 32'(acc_out), 32'd12);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        check("last_on_count_no_repeat", {31'd0, out_valid}, 32'd0);

        // Mid-frame asynchronous reset between edges.
        send(5'd2, 1'b0);
        send(5'd2, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_acc_out", 32'(acc_out), 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        model_reset();
        #1 rst = 1'b0;
        cycle();                               // IDLE -> ACCUM edge
        repeat (4) send(5'd2, 1'b0);
        in_valid = 1'b0;
        check("post_rst_acc", 32'(acc_out), 32'd8);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;

        // Overflow on the COUNT=10 instance: 10 x 31 = 310.
        b_in_valid = 1'b1; {b_cout, b_s} = 5'd31;
        repeat (10) cycle();
        b_in_valid = 1'b0;
        check("big_valid", {31'd0, b_out_valid}, 32'd1);
        check("big_acc", 32'(b_acc_out), 32'(exp_result(310)));
        check("big_ovf", {31'd0, b_ovf}, 32'd1);
        check("big_not_ready", {31'd0, b_in_ready}, 32'd0);
        b_out_ready = 1'b1;
        cycle();
        b_out_ready = 1'b0;
        check("big_release_ovf", {31'd0, b_ovf}, 32'd0);
        // Next frame: 1+1+1 ended by in_last, no overflow.
        b_in_valid = 1'b1; {b_cout, b_s} = 5'd1;
        cycle();
        cycle();
        b_in_last = 1'b1;
        cycle();
        b_in_valid = 1'b0; b_in_last = 1'b0;
        check("big_next_valid", {31'd0, b_out_valid}, 32'd1);
        check("big_next_acc", 32'(b_acc_out), 32'd3);
        check("big_next_ovf", {31'd0, b_ovf}, 32'd0);
        b_out_ready = 1'b1;
        cycle();
        b_out_ready = 1'b0;

        // Randomized traffic on u_dut against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            {cout, s} = 5'($urandom_range(0, 31));
            in_last   = ($urandom_range(0, 4) == 0);
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
